reset_sequencer: RTL and testbench

Staged reset-release controller that sits directly downstream of the clocked reset synchronizer. It takes the synchronized, active-high system reset and releases NSTAGES downstream reset domains one at a time, in index order. Each stage is released only after the previous stage has acknowledged readiness (PLL lock, calibration done) and a fixed gap has elapsed. It reports completion, per-stage timeout and loss of ack, and supports a software-requested re-sequence without a full system reset.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset-release sequencer.
// Holds the FSM state encoding, the counter sizing function and the parameter legality check.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  // One counter serves both the release gap and the ack timeout, so it is sized for the larger.
  function automatic int cnt_width(input int gap_cycles, input int timeout);
    int max_val;
    max_val = (gap_cycles > timeout) ? gap_cycles : timeout;
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic bit params_legal(input int nstages, input int gap_cycles, input int timeout);
    return (nstages >= 1) && (nstages <= 16) && (gap_cycles >= 1) && (timeout >= 2);
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases NSTAGES downstream reset domains one at a time, each after the previous stage acks
// and a fixed gap elapses; flags timeouts and ack loss, and restarts on a software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NSTAGES    = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                      CLK,
  input  logic                                      IN_RST,
  input  logic                                      sw_rst_req,
  input  logic [NSTAGES-1:0]                        stage_ack,
  output logic [NSTAGES-1:0]                        stage_rst,
  output logic                                      seq_done,
  output logic                                      seq_error,
  output logic [((NSTAGES > 1) ? $clog2(NSTAGES) : 1)-1:0] err_stage,
  output logic                                      busy
);

  localparam int IDX_W = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam int CNT_W = cnt_width(GAP_CYCLES, TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NSTAGES - 1);

  generate
    if (!params_legal(NSTAGES, GAP_CYCLES, TIMEOUT)) begin : g_bad_params
      $error("reset_sequencer: illegal NSTAGES/GAP_CYCLES/TIMEOUT combination");
    end
  endgenerate

  seq_state_t           state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [NSTAGES-1:0]   stage_rst_n;
  logic                 seq_done_n, seq_error_n;
  logic [IDX_W-1:0]     err_stage_n;
  logic [IDX_W-1:0]     low_idx;
  logic                 any_low;

  // Lowest-indexed dropped ack, reported when a released domain loses readiness.
  always_comb begin
    low_idx = '0;
    any_low = ~&stage_ack;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      if (!stage_ack[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge CLK or posedge IN_RST) begin
    if (IN_RST) begin
      state     <= ST_GAP;
      idx       <= '0;
      cnt       <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      seq_error <= 1'b0;
      err_stage <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      stage_rst <= stage_rst_n;
      seq_done  <= seq_done_n;
      seq_error <= seq_error_n;
      err_stage <= err_stage_n;
    end
  end

  // Software restart outranks every in-flight event; ack outranks timeout on the same edge.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    stage_rst_n = stage_rst;
    seq_done_n  = seq_done;
    seq_error_n = seq_error;
    err_stage_n = err_stage;
    if (sw_rst_req) begin
      state_n     = ST_GAP;
      idx_n       = '0;
      cnt_n       = '0;
      stage_rst_n = '1;
      seq_done_n  = 1'b0;
      seq_error_n = 1'b0;
      err_stage_n = '0;
    end else begin
      case (state)
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            stage_rst_n[idx] = 1'b0;
            cnt_n            = '0;
            state_n          = ST_WAIT_ACK;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (stage_ack[idx]) begin
            if (idx == IDX_LAST) begin
              state_n    = ST_DONE;
              seq_done_n = 1'b1;
            end else begin
              idx_n   = idx + IDX_W'(1);
              cnt_n   = '0;
              state_n = ST_GAP;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state_n     = ST_FAIL;
            seq_error_n = 1'b1;
            err_stage_n = idx;
            stage_rst_n = '1;
            seq_done_n  = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (any_low) begin
            state_n     = ST_FAIL;
            seq_error_n = 1'b1;
            err_stage_n = low_idx;
            stage_rst_n = '1;
            seq_done_n  = 1'b0;
          end
        end
        default: begin
          state_n = ST_FAIL;
        end
      endcase
    end
  end

  assign busy = (state == ST_GAP) || (state == ST_WAIT_ACK);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with NSTAGES=4, GAP_CYCLES=16, TIMEOUT=1024.
// Inputs change and outputs are sampled 1 time unit after a rising edge, or at the falling edge.
module tb_reset_sequencer;

  logic       CLK;
  logic       IN_RST;
  logic       sw_rst_req;
  logic [3:0] stage_ack;
  logic [3:0] stage_rst;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_stage;
  logic       busy;

  int tests_run;
  int tests_failed;

  reset_sequencer #(
    .NSTAGES    (4),
    .GAP_CYCLES (16),
    .TIMEOUT    (1024)
  ) dut (
    .CLK        (CLK),
    .IN_RST     (IN_RST),
    .sw_rst_req (sw_rst_req),
    .stage_ack  (stage_ack),
    .stage_rst  (stage_rst),
    .seq_done   (seq_done),
    .seq_error  (seq_error),
    .err_stage  (err_stage),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Leaves IN_RST released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    IN_RST     = 1'b1;
    sw_rst_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    IN_RST = 1'b0;
  endtask

  task automatic test_reset();
    stage_ack = 4'b1111;
    IN_RST    = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (stage_rst !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL reset_stage_rst got=%b exp=%b", stage_rst, 4'b1111);
    end
    tests_run++;
    if ({seq_done, seq_error, err_stage, busy} !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got done=%b err=%b stg=%0d busy=%b exp 0 0 0 1",
               seq_done, seq_error, err_stage, busy);
    end
  endtask

  task automatic test_normal_sequence();
    logic [3:0] exp_rst;
    logic       exp_done;
    stage_ack = 4'b1111;
    do_reset();
    for (int e = 1; e <= 72; e++) begin
      wait_edges(1);
      for (int i = 0; i < 4; i++) exp_rst[i] = (e < (i + 1) * 16 + i);
      exp_done = (e >= 68);
      tests_run++;
      if ({stage_rst, seq_done, busy} !== {exp_rst, exp_done, ~exp_done}) begin
        tests_failed++;
        $display("[TB] FAIL normal_seq edge=%0d got rst=%b done=%b busy=%b exp rst=%b done=%b busy=%b",
                 e, stage_rst, seq_done, busy, exp_rst, exp_done, ~exp_done);
      end
    end
  endtask

  task automatic test_timeout();
    stage_ack = 4'b1011;
    do_reset();
    wait_edges(1073);
    tests_run++;
    if ({seq_error, busy, stage_rst} !== {1'b0, 1'b1, 4'b1000}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_before got err=%b busy=%b rst=%b exp 0 1 1000",
               seq_error, busy, stage_rst);
    end
    wait_edges(1);
    tests_run++;
    if ({seq_error, err_stage, stage_rst, seq_done, busy} !== {1'b1, 2'd2, 4'b1111, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_fail got err=%b stg=%0d rst=%b done=%b busy=%b exp 1 2 1111 0 0",
               seq_error, err_stage, stage_rst, seq_done, busy);
    end
    for (int k = 0; k < 20; k++) begin
      wait_edges(100);
      tests_run++;
      if ({seq_error, err_stage, stage_rst} !== {1'b1, 2'd2, 4'b1111}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_hold k=%0d got err=%b stg=%0d rst=%b exp 1 2 1111",
                 k, seq_error, err_stage, stage_rst);
      end
    end
  endtask

  task automatic test_ack_loss();
    stage_ack = 4'b1111;
    do_reset();
    wait_edges(68);
    tests_run++;
    if ({seq_done, stage_rst} !== {1'b1, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL ackloss_done got done=%b rst=%b exp 1 0000", seq_done, stage_rst);
    end
    stage_ack = 4'b1101;
    wait_edges(1);
    stage_ack = 4'b1111;
    tests_run++;
    if ({seq_error, err_stage, seq_done, stage_rst} !== {1'b1, 2'd1, 1'b0, 4'b1111}) begin
      tests_failed++;
      $display("[TB] FAIL ackloss_fail got err=%b stg=%0d done=%b rst=%b exp 1 1 0 1111",
               seq_error, err_stage, seq_done, stage_rst);
    end
    wait_edges(5);
    tests_run++;
    if ({seq_error, stage_rst, busy} !== {1'b1, 4'b1111, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL ackloss_hold got err=%b rst=%b busy=%b exp 1 1111 0",
               seq_error, stage_rst, busy);
    end
  endtask

  // Starts from the FAIL state left by test_ack_loss.
  task automatic test_sw_reset_from_fail();
    stage_ack  = 4'b1111;
    sw_rst_req = 1'b1;
    wait_edges(1);
    sw_rst_req = 1'b0;
    tests_run++;
    if ({seq_error, err_stage, stage_rst, busy} !== {1'b0, 2'd0, 4'b1111, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL swrst_clear got err=%b stg=%0d rst=%b busy=%b exp 0 0 1111 1",
               seq_error, err_stage, stage_rst, busy);
    end
    wait_edges(15);
    tests_run++;
    if (stage_rst !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL swrst_edge15 got rst=%b exp 1111", stage_rst);
    end
    wait_edges(1);
    tests_run++;
    if (stage_rst !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL swrst_edge16 got rst=%b exp 1110", stage_rst);
    end
    wait_edges(51);
    tests_run++;
    if (seq_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL swrst_edge67 got done=%b exp 0", seq_done);
    end
    wait_edges(1);
    tests_run++;
    if ({seq_done, stage_rst} !== {1'b1, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL swrst_edge68 got done=%b rst=%b exp 1 0000", seq_done, stage_rst);
    end
  endtask

  task automatic test_async_reset();
    stage_ack = 4'b0000;
    do_reset();
    wait_edges(20);
    tests_run++;
    if ({stage_rst, busy} !== {4'b1110, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL async_pre got rst=%b busy=%b exp 1110 1", stage_rst, busy);
    end
    #2;
    IN_RST = 1'b1;
    #1;
    tests_run++;
    if ({stage_rst, seq_done, seq_error, busy} !== {4'b1111, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL async_waitack got rst=%b done=%b err=%b busy=%b exp 1111 0 0 1",
               stage_rst, seq_done, seq_error, busy);
    end
    stage_ack = 4'b1111;
    do_reset();
    wait_edges(68);
    #3;
    IN_RST = 1'b1;
    #1;
    tests_run++;
    if ({stage_rst, seq_done, busy} !== {4'b1111, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL async_done got rst=%b done=%b busy=%b exp 1111 0 1",
               stage_rst, seq_done, busy);
    end
  endtask

  // Stage 0 releases at edge 16, so its last timeout edge is 16+1024 = 1040.
  task automatic test_ack_at_timeout();
    stage_ack = 4'b0000;
    do_reset();
    wait_edges(1039);
    stage_ack = 4'b0001;
    wait_edges(1);
    tests_run++;
    if ({seq_error, busy, stage_rst} !== {1'b0, 1'b1, 4'b1110}) begin
      tests_failed++;
      $display("[TB] FAIL ack_at_timeout got err=%b busy=%b rst=%b exp 0 1 1110",
               seq_error, busy, stage_rst);
    end
    stage_ack = 4'b1111;
    wait_edges(15);
    tests_run++;
    if (stage_rst !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL ack_at_timeout_gap got rst=%b exp 1110", stage_rst);
    end
    wait_edges(1);
    tests_run++;
    if ({stage_rst, seq_error} !== {4'b1100, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL ack_at_timeout_next got rst=%b err=%b exp 1100 0", stage_rst, seq_error);
    end
  endtask

  task automatic test_sw_rst_at_timeout();
    stage_ack = 4'b0000;
    do_reset();
    wait_edges(1039);
    sw_rst_req = 1'b1;
    wait_edges(1);
    sw_rst_req = 1'b0;
    tests_run++;
    if ({seq_error, busy, stage_rst} !== {1'b0, 1'b1, 4'b1111}) begin
      tests_failed++;
      $display("[TB] FAIL swrst_at_timeout got err=%b busy=%b rst=%b exp 0 1 1111",
               seq_error, busy, stage_rst);
    end
    stage_ack = 4'b1111;
    wait_edges(16);
    tests_run++;
    if ({stage_rst, seq_error} !== {4'b1110, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL swrst_at_timeout_restart got rst=%b err=%b exp 1110 0",
               stage_rst, seq_error);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    IN_RST       = 1'b1;
    sw_rst_req   = 1'b0;
    stage_ack    = 4'b0000;
    test_reset();
    test_normal_sequence();
    test_timeout();
    test_ack_loss();
    test_sw_reset_from_fail();
    test_async_reset();
    test_ack_at_timeout();
    test_sw_rst_at_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
